// File: rtl/jpeg_rle_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jpeg_rle_seq : collects a 64-coefficient zigzag block and packs its nonzero
//                coefficients as {run, coef} entries plus leading/trailing zeros
// Revision: 1.0
// ---------------------------------------------------------------------------
module jpeg_rle_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_coef,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   left,
  output logic [5:0]   right,
  output logic         flag,
  output logic [895:0] array,
  output logic [6:0]   size
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t         state_q;
  logic [5:0]     idx_q;
  logic [6:0]     zrun_q;
  logic [5:0]     left_q;
  logic [5:0]     right_q;
  logic           flag_q;
  logic [895:0]   array_q;
  logic [6:0]     size_q;
  logic           in_ready_q;
  logic           out_valid_q;

  logic           acc_d;
  logic           nz_d;
  logic [6:0]     zrun_d;
  logic [5:0]     right_d;
  logic [13:0]    entry_d;

  always_comb begin
    acc_d   = in_valid && in_ready_q;
    nz_d    = |in_coef;
    zrun_d  = nz_d ? 7'd0 : zrun_q + 7'd1;
    // The first nonzero carries run 0; its leading zeros go to left instead.
    entry_d = {(flag_q ? zrun_q[5:0] : 6'd0), in_coef};
    right_d = (flag_q || nz_d) ? zrun_d[5:0] : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      zrun_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      flag_q      <= 1'b0;
      array_q     <= '0;
      size_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (acc_d) begin
            state_q <= COLLECT;
            idx_q   <= idx_q + 6'd1;
            zrun_q  <= zrun_d;
            if (nz_d) begin
              if (!flag_q) left_q <= zrun_q[5:0];
              flag_q  <= 1'b1;
              array_q <= {array_q[881:0], entry_d};
              size_q  <= size_q + 7'd1;
            end
            if (idx_q == 6'd63) begin
              state_q     <= DONE;
              right_q     <= right_d;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            zrun_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            flag_q      <= 1'b0;
            array_q     <= '0;
            size_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign left      = left_q;
  assign right     = right_q;
  assign flag      = flag_q;
  assign array     = array_q;
  assign size      = size_q;

endmodule
`default_nettype wire
